// File: rtl/rsa256_uart_bridge_if.sv
// Avalon-MM bus bundle between the RSA bridge (master) and the UART register file (slave).
// Only bits [7:0] of the data buses carry payload.
interface rsa256_uart_bridge_if;
  logic [4:0]  avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_readdata,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_readdata,
    output avm_waitrequest
  );
endinterface

// File: rtl/rsa256_uart_bridge.sv
// Polls the UART for the key (n, d) once, then for each 256-bit ciphertext block runs the
// RSA core and streams the 31-byte plaintext back out through the UART.
module rsa256_uart_bridge #(
  parameter int RX_BASE     = 0,
  parameter int TX_BASE     = 4,
  parameter int STATUS_BASE = 8,
  parameter int RX_OK_BIT   = 7,
  parameter int TX_OK_BIT   = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  rsa256_uart_bridge_if.master avm,
  output logic                 o_core_start,
  output logic [255:0]         o_core_a,
  output logic [255:0]         o_core_e,
  output logic [255:0]         o_core_n,
  input  logic [255:0]         i_core_result,
  input  logic                 i_core_finished
);

  localparam logic [4:0] RX_ADDR     = RX_BASE[4:0];
  localparam logic [4:0] TX_ADDR     = TX_BASE[4:0];
  localparam logic [4:0] STATUS_ADDR = STATUS_BASE[4:0];

  typedef enum logic [2:0] {
    S_QUERY_RX,
    S_READ,
    S_CALC_ARM,
    S_CALC,
    S_QUERY_TX,
    S_WRITE
  } state_e;

  typedef enum logic [1:0] {
    PH_KEY_N,
    PH_KEY_D,
    PH_DATA
  } phase_e;

  state_e       state_q;
  phase_e       phase_q;
  logic [4:0]   rx_cnt_q;
  logic [4:0]   tx_cnt_q;
  logic [255:0] n_q, d_q, a_q;
  logic [255:0] n_d, d_d, a_d;
  logic [247:0] tx_q;
  logic         read_q;
  logic         write_q;
  logic [4:0]   addr_q;
  logic [7:0]   wdata_q;
  logic         start_q;

  logic       accept;
  logic [7:0] rx_byte;
  logic       unused_ok;

  assign accept    = (read_q | write_q) & ~avm.avm_waitrequest;
  assign rx_byte   = avm.avm_readdata[7:0];
  assign unused_ok = &{1'b0, avm.avm_readdata, i_core_result[255:248]};

  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = {24'h000000, wdata_q};

  assign o_core_start = start_q;
  assign o_core_a     = a_q;
  assign o_core_e     = d_q;
  assign o_core_n     = n_q;

  // Phase steers each received byte into exactly one of the three MSB-first shift registers.
  always_comb begin
    n_d = n_q;
    d_d = d_q;
    a_d = a_q;
    if (state_q == S_READ && accept) begin
      case (phase_q)
        PH_KEY_N: n_d = {n_q[247:0], rx_byte};
        PH_KEY_D: d_d = {d_q[247:0], rx_byte};
        default:  a_d = {a_q[247:0], rx_byte};
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= S_QUERY_RX;
      phase_q  <= PH_KEY_N;
      rx_cnt_q <= 5'd0;
      tx_cnt_q <= 5'd0;
      n_q      <= '0;
      d_q      <= '0;
      a_q      <= '0;
      tx_q     <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= STATUS_ADDR;
      wdata_q  <= 8'h00;
      start_q  <= 1'b0;
    end else begin
      start_q <= 1'b0;
      n_q     <= n_d;
      d_q     <= d_d;
      a_q     <= a_d;
      case (state_q)
        // A dropped request is re-raised on the following cycle, giving the one-cycle gap.
        S_QUERY_RX: begin
          if (!read_q) begin
            read_q <= 1'b1;
          end else if (accept) begin
            read_q <= 1'b0;
            if (avm.avm_readdata[RX_OK_BIT]) begin
              state_q <= S_READ;
              addr_q  <= RX_ADDR;
            end
          end
        end

        S_READ: begin
          if (!read_q) begin
            read_q <= 1'b1;
          end else if (accept) begin
            read_q <= 1'b0;
            addr_q <= STATUS_ADDR;
            if (rx_cnt_q == 5'd31) begin
              rx_cnt_q <= 5'd0;
              case (phase_q)
                PH_KEY_N: begin
                  phase_q <= PH_KEY_D;
                  state_q <= S_QUERY_RX;
                end
                PH_KEY_D: begin
                  phase_q <= PH_DATA;
                  state_q <= S_QUERY_RX;
                end
                default: begin
                  state_q <= S_CALC_ARM;
                  start_q <= 1'b1;
                end
              endcase
            end else begin
              rx_cnt_q <= rx_cnt_q + 5'd1;
              state_q  <= S_QUERY_RX;
            end
          end
        end

        // The core reports finished while idle, so wait for it to go busy before trusting a rise.
        S_CALC_ARM: begin
          if (!i_core_finished) begin
            state_q <= S_CALC;
          end
        end

        S_CALC: begin
          if (i_core_finished) begin
            tx_q     <= i_core_result[247:0];
            tx_cnt_q <= 5'd0;
            state_q  <= S_QUERY_TX;
          end
        end

        S_QUERY_TX: begin
          if (!read_q) begin
            read_q <= 1'b1;
          end else if (accept) begin
            read_q <= 1'b0;
            if (avm.avm_readdata[TX_OK_BIT]) begin
              state_q <= S_WRITE;
              addr_q  <= TX_ADDR;
              wdata_q <= tx_q[247:240];
            end
          end
        end

        S_WRITE: begin
          if (!write_q) begin
            write_q <= 1'b1;
          end else if (accept) begin
            write_q <= 1'b0;
            tx_q    <= {tx_q[239:0], 8'h00};
            addr_q  <= STATUS_ADDR;
            if (tx_cnt_q == 5'd30) begin
              tx_cnt_q <= 5'd0;
              state_q  <= S_QUERY_RX;
            end else begin
              tx_cnt_q <= tx_cnt_q + 5'd1;
              state_q  <= S_QUERY_TX;
            end
          end
        end

        default: begin
          state_q <= S_QUERY_RX;
        end
      endcase
    end
  end

endmodule
